// File: rtl/vesa_timing_pkg.sv
// Shared types and constants for the VESA raster timing generator:
// controller states, 1920x1080 reduced-blanking defaults, config field layout.
package vesa_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 80;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 8;
    localparam int DEF_V_BP     = 20;

    // Field index inside a packed {active, fp, sync, bp} word; multiply by CNT_W for the bit offset.
    localparam int CFG_ACTIVE_FLD = 3;
    localparam int CFG_FP_FLD     = 2;
    localparam int CFG_SYNC_FLD   = 1;
    localparam int CFG_BP_FLD     = 0;

    localparam int POL_H_BIT = 0;
    localparam int POL_V_BIT = 1;

endpackage

// File: rtl/vesa_axis_decode.sv
// One axis of raster decode: active-region flag and polarity-adjusted sync window.
module vesa_axis_decode #(
    parameter int unsigned CNT_W = 12
) (
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] active,
    input  logic [CNT_W-1:0] fp,
    input  logic [CNT_W-1:0] sync_len,
    input  logic             pol,
    output logic             in_active,
    output logic             sync
);

    logic [CNT_W+1:0] sync_start;
    logic [CNT_W+1:0] sync_end;
    logic [CNT_W+1:0] count_w;

    assign count_w    = {2'b00, count};
    assign sync_start = {2'b00, active} + {2'b00, fp};
    assign sync_end   = sync_start + {2'b00, sync_len};
    assign in_active  = (count < active);
    // pol=0 means active-low: the window flag is inverted.
    assign sync       = ((count_w >= sync_start) && (count_w < sync_end)) ^ ~pol;

endmodule

// File: rtl/vesa_timing_gen.sv
// Programmable VESA raster timing generator with frame-boundary config updates
// and a run/drain controller so frames are never truncated by en.
module vesa_timing_gen #(
    parameter int unsigned CNT_W        = 12,
    parameter int          DEF_H_ACTIVE = vesa_timing_pkg::DEF_H_ACTIVE,
    parameter int          DEF_H_FP     = vesa_timing_pkg::DEF_H_FP,
    parameter int          DEF_H_SYNC   = vesa_timing_pkg::DEF_H_SYNC,
    parameter int          DEF_H_BP     = vesa_timing_pkg::DEF_H_BP,
    parameter int          DEF_V_ACTIVE = vesa_timing_pkg::DEF_V_ACTIVE,
    parameter int          DEF_V_FP     = vesa_timing_pkg::DEF_V_FP,
    parameter int          DEF_V_SYNC   = vesa_timing_pkg::DEF_V_SYNC,
    parameter int          DEF_V_BP     = vesa_timing_pkg::DEF_V_BP,
    parameter bit          DEF_HPOL     = 1'b0,
    parameter bit          DEF_VPOL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [4*CNT_W-1:0] cfg_h,
    input  logic [4*CNT_W-1:0] cfg_v,
    input  logic [1:0]         cfg_pol,
    output logic               cfg_err,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_valid,
    output logic               sof,
    output logic               eol,
    output logic [CNT_W-1:0]   h_count,
    output logic [CNT_W-1:0]   v_count
);
    import vesa_timing_pkg::*;

    localparam logic [CNT_W-1:0] DEF_H_TOT = CNT_W'(DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP);
    localparam logic [CNT_W-1:0] DEF_V_TOT = CNT_W'(DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP);

    state_t state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] h_act_q, h_act_d, h_fp_q, h_fp_d, h_sync_q, h_sync_d, h_tot_q, h_tot_d;
    logic [CNT_W-1:0] v_act_q, v_act_d, v_fp_q, v_fp_d, v_sync_q, v_sync_d, v_tot_q, v_tot_d;
    logic [1:0]       pol_q, pol_d, p_pol_q, p_pol_d;
    logic [4*CNT_W-1:0] p_h_q, p_h_d, p_v_q, p_v_d;
    logic pend_q, pend_d, cfg_err_q, cfg_err_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fv_q, fv_d, sof_q, sof_d, eol_q, eol_d;

    logic [CNT_W+1:0] in_h_tot, in_v_tot, p_h_tot, p_v_tot;
    logic cfg_take, cfg_legal, last_pix, apply, running;
    logic h_in_act, v_in_act, h_sync_w, v_sync_w;

    function automatic logic [CNT_W-1:0] fld(input logic [4*CNT_W-1:0] w, input int idx);
        return w[idx*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W+1:0] total(input logic [4*CNT_W-1:0] w);
        return {2'b00, fld(w, CFG_ACTIVE_FLD)} + {2'b00, fld(w, CFG_FP_FLD)}
             + {2'b00, fld(w, CFG_SYNC_FLD)} + {2'b00, fld(w, CFG_BP_FLD)};
    endfunction

    vesa_axis_decode #(.CNT_W(CNT_W)) u_h_dec (
        .count(h_cnt_q), .active(h_act_q), .fp(h_fp_q), .sync_len(h_sync_q),
        .pol(pol_q[POL_H_BIT]), .in_active(h_in_act), .sync(h_sync_w)
    );

    vesa_axis_decode #(.CNT_W(CNT_W)) u_v_dec (
        .count(v_cnt_q), .active(v_act_q), .fp(v_fp_q), .sync_len(v_sync_q),
        .pol(pol_q[POL_V_BIT]), .in_active(v_in_act), .sync(v_sync_w)
    );

    // Handshake: a config transfers on any cycle with cfg_valid && cfg_ready; legality is judged afterwards.
    assign cfg_ready = !pend_q;
    assign cfg_take  = cfg_valid && cfg_ready;
    assign in_h_tot  = total(cfg_h);
    assign in_v_tot  = total(cfg_v);
    assign p_h_tot   = total(p_h_q);
    assign p_v_tot   = total(p_v_q);
    assign cfg_legal = (fld(cfg_h, CFG_ACTIVE_FLD) != '0) && (fld(cfg_h, CFG_SYNC_FLD) != '0)
                    && (fld(cfg_v, CFG_ACTIVE_FLD) != '0) && (fld(cfg_v, CFG_SYNC_FLD) != '0)
                    && (in_h_tot <= {2'b00, {CNT_W{1'b1}}})
                    && (in_v_tot <= {2'b00, {CNT_W{1'b1}}});

    assign running  = (state_q != ST_IDLE);
    assign last_pix = running && (h_cnt_q == h_tot_q - CNT_W'(1)) && (v_cnt_q == v_tot_q - CNT_W'(1));
    assign apply    = pend_q && (!running || last_pix);

    always_comb begin
        state_d   = state_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        h_act_d   = h_act_q;  h_fp_d = h_fp_q;  h_sync_d = h_sync_q;  h_tot_d = h_tot_q;
        v_act_d   = v_act_q;  v_fp_d = v_fp_q;  v_sync_d = v_sync_q;  v_tot_d = v_tot_q;
        pol_d     = pol_q;
        p_h_d     = p_h_q;
        p_v_d     = p_v_q;
        p_pol_d   = p_pol_q;
        pend_d    = pend_q;
        cfg_err_d = cfg_take && !cfg_legal;

        if (cfg_take && cfg_legal) begin
            p_h_d   = cfg_h;
            p_v_d   = cfg_v;
            p_pol_d = cfg_pol;
            pend_d  = 1'b1;
        end
        if (apply) begin
            h_act_d  = fld(p_h_q, CFG_ACTIVE_FLD);
            h_fp_d   = fld(p_h_q, CFG_FP_FLD);
            h_sync_d = fld(p_h_q, CFG_SYNC_FLD);
            h_tot_d  = p_h_tot[CNT_W-1:0];
            v_act_d  = fld(p_v_q, CFG_ACTIVE_FLD);
            v_fp_d   = fld(p_v_q, CFG_FP_FLD);
            v_sync_d = fld(p_v_q, CFG_SYNC_FLD);
            v_tot_d  = p_v_tot[CNT_W-1:0];
            pol_d    = p_pol_q;
            pend_d   = 1'b0;
        end

        if (!running) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == h_tot_q - CNT_W'(1)) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == v_tot_q - CNT_W'(1)) ? '0 : v_cnt_q + CNT_W'(1);
        end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end

        // Dropping en only ever ends on a frame boundary.
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = last_pix ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (en) state_d = ST_RUN;
                      else if (last_pix) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        de_d    = running && h_in_act && v_in_act;
        fv_d    = running && v_in_act;
        sof_d   = de_d && (h_cnt_q == '0) && (v_cnt_q == '0);
        eol_d   = de_d && (h_cnt_q == h_act_q - CNT_W'(1));
        hsync_d = running ? h_sync_w : ~pol_q[POL_H_BIT];
        vsync_d = running ? v_sync_w : ~pol_q[POL_V_BIT];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_act_q   <= CNT_W'(DEF_H_ACTIVE);
            h_fp_q    <= CNT_W'(DEF_H_FP);
            h_sync_q  <= CNT_W'(DEF_H_SYNC);
            h_tot_q   <= DEF_H_TOT;
            v_act_q   <= CNT_W'(DEF_V_ACTIVE);
            v_fp_q    <= CNT_W'(DEF_V_FP);
            v_sync_q  <= CNT_W'(DEF_V_SYNC);
            v_tot_q   <= DEF_V_TOT;
            pol_q     <= {DEF_VPOL, DEF_HPOL};
            p_h_q     <= '0;
            p_v_q     <= '0;
            p_pol_q   <= '0;
            pend_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            hsync_q   <= ~DEF_HPOL;
            vsync_q   <= ~DEF_VPOL;
            de_q      <= 1'b0;
            fv_q      <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            h_act_q   <= h_act_d;
            h_fp_q    <= h_fp_d;
            h_sync_q  <= h_sync_d;
            h_tot_q   <= h_tot_d;
            v_act_q   <= v_act_d;
            v_fp_q    <= v_fp_d;
            v_sync_q  <= v_sync_d;
            v_tot_q   <= v_tot_d;
            pol_q     <= pol_d;
            p_h_q     <= p_h_d;
            p_v_q     <= p_v_d;
            p_pol_q   <= p_pol_d;
            pend_q    <= pend_d;
            cfg_err_q <= cfg_err_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            de_q      <= de_d;
            fv_q      <= fv_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
        end
    end

    assign cfg_err     = cfg_err_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_valid = fv_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign h_count     = h_cnt_q;
    assign v_count     = v_cnt_q;

endmodule

// File: tb/tb_vesa_timing_gen.sv
// Directed bench for vesa_timing_gen: default 1080p line timing, small programmed
// rasters, frame-boundary config hand-over, illegal configs, drain and async reset.
module tb_vesa_timing_gen;

    localparam int CNT_W = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [4*CNT_W-1:0] cfg_h = '0;
    logic [4*CNT_W-1:0] cfg_v = '0;
    logic [1:0]         cfg_pol = 2'b00;
    logic               cfg_err, hsync, vsync, de, frame_valid, sof, eol;
    logic [CNT_W-1:0]   h_count, v_count;

    int n_vec = 0;
    int n_err = 0;

    vesa_timing_gen #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol), .cfg_err(cfg_err),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_valid(frame_valid),
        .sof(sof), .eol(eol), .h_count(h_count), .v_count(v_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until the counters read (h,v); bounded so a stuck raster still reaches the summary.
    task automatic wait_hv(input int h, input int v, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            step(1);
            if (h_count == CNT_W'(h) && v_count == CNT_W'(v)) found = 1'b1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    function automatic logic [4*CNT_W-1:0] pack4(input int a, input int f, input int s, input int b);
        return {CNT_W'(a), CNT_W'(f), CNT_W'(s), CNT_W'(b)};
    endfunction

    task automatic offer(input logic [4*CNT_W-1:0] h, input logic [4*CNT_W-1:0] v, input logic [1:0] p);
        cfg_h = h;
        cfg_v = v;
        cfg_pol = p;
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
    endtask

    // Count output activity over n cycles; any n-cycle window of an n-cycle frame sees each phase once.
    task automatic window(input int n, output int c_de, output int c_sof, output int c_eol,
                          output int c_hs, output int c_vs);
        c_de = 0; c_sof = 0; c_eol = 0; c_hs = 0; c_vs = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            c_de += int'(de); c_sof += int'(sof); c_eol += int'(eol);
            c_hs += int'(hsync); c_vs += int'(vsync);
        end
    endtask

    int c_de, c_sof, c_eol, c_hs, c_vs;

    initial begin
        #12;
        check("rst_h", 32'(h_count), 0);
        check("rst_v", 32'(v_count), 0);
        check("rst_de", 32'(de), 0);
        check("rst_fv", 32'(frame_valid), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_ready", 32'(cfg_ready), 1);
        check("rst_err", 32'(cfg_err), 0);

        // Default 1920x1080 raster, first line only.
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);
        check("idle_hold", 32'(h_count), 0);
        en = 1'b1;
        step(2);
        check("run_h1", 32'(h_count), 1);
        check("first_de", 32'(de), 1);
        check("first_sof", 32'(sof), 1);
        check("first_fv", 32'(frame_valid), 1);
        check("first_hsync", 32'(hsync), 1);
        step(1);
        check("sof_pulse_end", 32'(sof), 0);
        wait_hv(1920, 0, "reach_h1920");
        check("eol_de", 32'(de), 1);
        check("eol_pulse", 32'(eol), 1);
        step(1);
        check("blank_de", 32'(de), 0);
        check("eol_end", 32'(eol), 0);
        wait_hv(1968, 0, "reach_h1968");
        check("hs_pre", 32'(hsync), 1);
        step(1);
        check("hs_start", 32'(hsync), 0);
        wait_hv(2000, 0, "reach_h2000");
        check("hs_last", 32'(hsync), 0);
        step(1);
        check("hs_end", 32'(hsync), 1);
        wait_hv(2079, 0, "reach_h2079");
        step(1);
        check("hwrap_h", 32'(h_count), 0);
        check("hwrap_v", 32'(v_count), 1);

        // Illegal configs are rejected with a one-cycle pulse.
        offer(pack4(0, 48, 32, 80), pack4(1080, 3, 8, 20), 2'b00);
        check("err_zero_act", 32'(cfg_err), 1);
        check("err_zero_ready", 32'(cfg_ready), 1);
        step(1);
        check("err_pulse_end", 32'(cfg_err), 0);
        offer(pack4(4000, 40, 40, 16), pack4(1080, 3, 8, 20), 2'b00);
        check("err_h4096", 32'(cfg_err), 1);
        check("err_h4096_ready", 32'(cfg_ready), 1);

        // Legal config left pending, then an async reset mid-line discards it.
        offer(pack4(1920, 48, 32, 80), pack4(1080, 3, 8, 20), 2'b00);
        check("pend_ready", 32'(cfg_ready), 0);
        check("pend_err", 32'(cfg_err), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_h", 32'(h_count), 0);
        check("async_v", 32'(v_count), 0);
        check("async_de", 32'(de), 0);
        check("async_hsync", 32'(hsync), 1);
        check("async_ready", 32'(cfg_ready), 1);
        en = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // 25x8 raster with active-high syncs, loaded while idle.
        offer(pack4(16, 2, 3, 4), pack4(4, 1, 1, 2), 2'b11);
        check("idle_pend", 32'(cfg_ready), 0);
        step(1);
        check("idle_apply", 32'(cfg_ready), 1);
        step(1);
        check("idle_hs_pol", 32'(hsync), 0);
        check("idle_vs_pol", 32'(vsync), 0);
        en = 1'b1;
        step(1);
        check("restart_h", 32'(h_count), 0);
        check("restart_v", 32'(v_count), 0);
        step(3);
        window(200, c_de, c_sof, c_eol, c_hs, c_vs);
        check("s_de", 32'(c_de), 64);
        check("s_sof", 32'(c_sof), 1);
        check("s_eol", 32'(c_eol), 4);
        check("s_hs", 32'(c_hs), 24);
        check("s_vs", 32'(c_vs), 25);

        // Mid-frame offer: old frame finishes at 24/7, new 12x5 raster starts at (0,0).
        wait_hv(5, 2, "reach_5_2");
        offer(pack4(8, 1, 2, 1), pack4(2, 1, 1, 1), 2'b00);
        check("mid_ready", 32'(cfg_ready), 0);
        wait_hv(24, 7, "old_frame_end");
        check("apply_ready", 32'(cfg_ready), 0);
        step(1);
        check("new_h0", 32'(h_count), 0);
        check("new_v0", 32'(v_count), 0);
        check("new_ready", 32'(cfg_ready), 1);
        wait_hv(11, 0, "new_h11");
        step(1);
        check("new_hwrap_h", 32'(h_count), 0);
        check("new_hwrap_v", 32'(v_count), 1);
        step(2);
        window(60, c_de, c_sof, c_eol, c_hs, c_vs);
        check("m_de", 32'(c_de), 16);
        check("m_sof", 32'(c_sof), 1);
        check("m_hs", 32'(c_hs), 50);
        check("m_vs", 32'(c_vs), 48);

        // Drop en mid-frame: the frame completes, then idle with inactive syncs.
        wait_hv(3, 1, "drain_start");
        en = 1'b0;
        wait_hv(11, 4, "drain_end");
        step(1);
        check("drain_wrap_h", 32'(h_count), 0);
        step(5);
        check("idle_h", 32'(h_count), 0);
        check("idle_v", 32'(v_count), 0);
        check("idle_de", 32'(de), 0);
        check("idle_fv", 32'(frame_valid), 0);
        check("idle_hsync", 32'(hsync), 1);
        check("idle_vsync", 32'(vsync), 1);

        // Re-raising en during drain continues without a restart.
        en = 1'b1;
        step(1);
        wait_hv(3, 1, "cont_start");
        en = 1'b0;
        step(1);
        check("cont_drain_h", 32'(h_count), 4);
        en = 1'b1;
        step(1);
        check("cont_run_h", 32'(h_count), 5);
        check("cont_run_v", 32'(v_count), 1);
        wait_hv(11, 4, "cont_end");
        step(2);
        check("cont_still_run", 32'(h_count), 1);

        en = 1'b0;
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
